data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter: MAX_WINDOW, 16, max consecutive accelerator beats before CPU is offered a slot (1..255).
REQ-002 SHALL have ports (name direction width meaning):
- clk in 1 system clock
- reset in 1 synchronous active-high reset
- cpu_req in 1 CPU load/store request (MEM stage)
- cpu_we in 1 CPU store when 1
- cpu_addr in 32 CPU byte address
- cpu_wdata in 32 CPU store data
- cpu_func3 in 3 CPU access size/sign
- cpu_rdata out 32 CPU load data
- cpu_stall out 1 freeze CPU pipeline
- acc_req in 1 GEMM DMA burst request
- acc_we in 1 burst is write when 1
- acc_addr in 32 burst base byte address
- acc_len in 8 burst length in words
- acc_wdata in 32 write data for current beat
- acc_gnt out 1 one-cycle burst accept pulse
- acc_beat out 1 a beat is performed this cycle (write data consumed / read data valid)
- acc_rdata out 32 read beat data
- acc_done out 1 one-cycle pulse with final beat
- mem_addr, mem_wdata out 32 to data memory
- mem_we, mem_re out 1 to data memory
- mem_func3 out 3 to data memory
- mem_rdata in 32 combinational read data from data memory
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, ACC_BURST, CPU_SLOT.
REQ-005 IDLE: if cpu_req, SHALL drive mem_* from cpu_* same cycle, cpu_stall=0; CPU has priority over acc_req.
REQ-006 IDLE, acc_req=1, cpu_req=0, acc_len!=0: SHALL pulse acc_gnt, latch addr/len/we, enter ACC_BURST next cycle.
REQ-007 IDLE, acc_req=1, cpu_req=0, acc_len=0: SHALL pulse acc_gnt and acc_done together, stay IDLE, no memory access.
REQ-008 ACC_BURST: one beat per cycle; mem_addr = base + 4*beat_index (mod 2^32), mem_func3=3'b010, mem_we=latched we, mem_re=!we, acc_beat=1, acc_rdata=mem_rdata.
REQ-009 ACC_BURST: cpu_stall SHALL equal cpu_req; acc_req ignored.
REQ-010 Window counter SHALL count consecutive beats; when it reaches MAX_WINDOW with beats remaining and cpu_req=1, next state CPU_SLOT; counter clears.
REQ-011 CPU_SLOT: exactly one cycle, serves CPU as in REQ-005, acc_beat=0; then returns to ACC_BURST at the next unperformed beat.
REQ-012 Final beat (beat_index=len-1): acc_done=1 same cycle; next state IDLE; final beat SHALL complete before any CPU slot.
REQ-013 When no access is selected, mem_we=mem_re=0; mem_addr/mem_wdata don't-care; cpu_rdata=mem_rdata always.
REQ-014 cpu_stall SHALL be 0 whenever cpu_req=0.

Reset
REQ-015 On reset: state IDLE, counters 0, latched registers 0; acc_gnt, acc_beat, acc_done, mem_we, mem_re = 0 the same cycle.
REQ-016 Reset mid-burst SHALL abort silently; no acc_done; remaining beats not performed.

Structure
REQ-017 Shared package SHALL hold the FSM state enum, WORD_FUNC3=3'b010, default MAX_WINDOW.
REQ-018 Sub-module burst_addr_gen (base latch, beat index, window counter, last-beat flag) is natural; FSM and muxing stay in top.

Verification
REQ-019 cpu_req store addr 0x100 data 0xDEADBEEF in IDLE -> mem_we=1 same cycle, cpu_stall=0, memory holds value.
REQ-020 acc read len=4 base 0x200, cpu idle -> acc_gnt cycle 0, acc_beat cycles 1-4 addrs 0x200-0x20C, acc_done cycle 4, IDLE cycle 5.
REQ-021 Same cycle cpu_req and acc_req in IDLE -> CPU served, acc_gnt=0; burst granted next cycle after cpu_req drops.
REQ-022 MAX_WINDOW=2, acc write len=5, cpu_req held high -> beats 0,1, CPU_SLOT, beats 2,3, CPU_SLOT, beat 4 with acc_done; cpu_stall=0 only in slots.
REQ-023 acc_len=0 -> acc_gnt and acc_done same cycle, no mem_we/mem_re.
REQ-024 Base 0xFFFFFFF8 len=3 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; reset asserted after beat 1 -> beat 2 absent, acc_done never pulses, state IDLE.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM states, word access code
// and the default accelerator window length.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACC_BURST = 2'd1,
        CPU_SLOT  = 2'd2
    } arbState_t;

    localparam logic [2:0] WORD_FUNC3         = 3'b010;
    localparam int         DEFAULT_MAX_WINDOW = 16;

endpackage

// File: rtl/data_mem_arbiter_burst_addr_gen.sv
// Burst bookkeeping: latched base/length/direction, beat index, window counter
// and the flags the arbiter FSM needs to schedule beats and CPU slots.
module data_mem_arbiter_burst_addr_gen
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_WINDOW = DEFAULT_MAX_WINDOW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] base_i,
    input  logic [7:0]  len_i,
    input  logic        we_i,
    input  logic        advance_i,
    input  logic        windowClear_i,
    output logic [31:0] addr_o,
    output logic        we_o,
    output logic        lastBeat_o,
    output logic        windowFull_o
);

    localparam logic [7:0] WIN_MAX  = 8'(MAX_WINDOW);
    localparam logic [7:0] WIN_LAST = 8'(MAX_WINDOW - 1);

    logic [31:0] base_q, base_d;
    logic [7:0]  len_q, len_d;
    logic        we_q, we_d;
    logic [7:0]  beatIdx_q, beatIdx_d;
    logic [7:0]  window_q, window_d;

    always_comb begin
        base_d    = base_q;
        len_d     = len_q;
        we_d      = we_q;
        beatIdx_d = beatIdx_q;
        window_d  = window_q;
        if (start_i) begin
            base_d    = base_i;
            len_d     = len_i;
            we_d      = we_i;
            beatIdx_d = 8'd0;
            window_d  = 8'd0;
        end else begin
            if (advance_i) begin
                beatIdx_d = beatIdx_q + 8'd1;
            end
            // The window saturates so a late CPU request still gets its slot.
            if (windowClear_i) begin
                window_d = 8'd0;
            end else if (advance_i && (window_q != WIN_MAX)) begin
                window_d = window_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q    <= 32'd0;
            len_q     <= 8'd0;
            we_q      <= 1'b0;
            beatIdx_q <= 8'd0;
            window_q  <= 8'd0;
        end else begin
            base_q    <= base_d;
            len_q     <= len_d;
            we_q      <= we_d;
            beatIdx_q <= beatIdx_d;
            window_q  <= window_d;
        end
    end

    assign addr_o       = base_q + {22'd0, beatIdx_q, 2'b00};
    assign we_o         = we_q;
    assign lastBeat_o   = (beatIdx_q == (len_q - 8'd1));
    assign windowFull_o = (window_q >= WIN_LAST);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single data memory port between the CPU MEM stage and the
// GEMM accelerator DMA, giving the CPU a slot every MAX_WINDOW burst beats.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_WINDOW = DEFAULT_MAX_WINDOW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_func3,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        acc_req,
    input  logic        acc_we,
    input  logic [31:0] acc_addr,
    input  logic [7:0]  acc_len,
    input  logic [31:0] acc_wdata,
    output logic        acc_gnt,
    output logic        acc_beat,
    output logic [31:0] acc_rdata,
    output logic        acc_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rdata
);

    arbState_t state_q, state_d;

    logic        burstStart;
    logic        burstAdvance;
    logic        windowClear;
    logic [31:0] beatAddr;
    logic        burstWe;
    logic        lastBeat;
    logic        windowFull;

    data_mem_arbiter_burst_addr_gen #(
        .MAX_WINDOW(MAX_WINDOW)
    ) u_addrGen (
        .clk          (clk),
        .reset        (reset),
        .start_i      (burstStart),
        .base_i       (acc_addr),
        .len_i        (acc_len),
        .we_i         (acc_we),
        .advance_i    (burstAdvance),
        .windowClear_i(windowClear),
        .addr_o       (beatAddr),
        .we_o         (burstWe),
        .lastBeat_o   (lastBeat),
        .windowFull_o (windowFull)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset gates every strobe combinationally so an aborted burst ends the same cycle.
    always_comb begin
        state_d      = state_q;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_func3    = cpu_func3;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        cpu_stall    = 1'b0;
        acc_gnt      = 1'b0;
        acc_beat     = 1'b0;
        acc_done     = 1'b0;
        burstStart   = 1'b0;
        burstAdvance = 1'b0;
        windowClear  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        mem_we = cpu_we;
                        mem_re = !cpu_we;
                    end else if (acc_req) begin
                        acc_gnt = 1'b1;
                        if (acc_len == 8'd0) begin
                            acc_done = 1'b1;
                        end else begin
                            burstStart = 1'b1;
                            state_d    = ACC_BURST;
                        end
                    end
                end
                ACC_BURST: begin
                    mem_addr     = beatAddr;
                    mem_wdata    = acc_wdata;
                    mem_func3    = WORD_FUNC3;
                    mem_we       = burstWe;
                    mem_re       = !burstWe;
                    acc_beat     = 1'b1;
                    cpu_stall    = cpu_req;
                    burstAdvance = 1'b1;
                    if (lastBeat) begin
                        acc_done = 1'b1;
                        state_d  = IDLE;
                    end else if (windowFull && cpu_req) begin
                        windowClear = 1'b1;
                        state_d     = CPU_SLOT;
                    end
                end
                CPU_SLOT: begin
                    if (cpu_req) begin
                        mem_we = cpu_we;
                        mem_re = !cpu_we;
                    end
                    state_d = ACC_BURST;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = mem_rdata;
    assign acc_rdata = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed stimulus pushes expected
// memory-port events, a negedge monitor pops and compares them.
module tb_data_mem_arbiter;

    localparam int TB_WINDOW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_func3;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        acc_req, acc_we;
    logic [31:0] acc_addr;
    logic [7:0]  acc_len;
    logic [31:0] acc_wdata;
    logic        acc_gnt, acc_beat, acc_done;
    logic [31:0] acc_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_re;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;

    logic [31:0] memArr [1024];

    typedef struct {
        bit          gnt, beat, done, we, re, stall;
        bit          chkAddr;
        logic [31:0] addr;
        logic [2:0]  func3;
        bit          chkRd;
        logic [31:0] rdata;
    } expRec_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } direct_t;

    expRec_t expQ[$];
    direct_t directQ[$];
    int      checks = 0;
    int      fails  = 0;
    int      evNum  = 0;
    bit      testDone = 1'b0;

    data_mem_arbiter #(.MAX_WINDOW(TB_WINDOW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
        .acc_len(acc_len), .acc_wdata(acc_wdata),
        .acc_gnt(acc_gnt), .acc_beat(acc_beat), .acc_rdata(acc_rdata),
        .acc_done(acc_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = memArr[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) memArr[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit cReq, input bit cWe, input logic [31:0] cAddr,
                                 input logic [31:0] cWdata, input logic [2:0] cF3,
                                 input bit aReq, input bit aWe, input logic [31:0] aAddr,
                                 input logic [7:0] aLen);
        cpu_req   = cReq;
        cpu_we    = cWe;
        cpu_addr  = cAddr;
        cpu_wdata = cWdata;
        cpu_func3 = cF3;
        acc_req   = aReq;
        acc_we    = aWe;
        acc_addr  = aAddr;
        acc_len   = aLen;
    endtask

    task automatic expectCpu(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] rd);
        expRec_t e;
        e = '{gnt: 1'b0, beat: 1'b0, done: 1'b0, we: we, re: !we, stall: 1'b0,
              chkAddr: 1'b1, addr: addr, func3: f3, chkRd: !we, rdata: rd};
        expQ.push_back(e);
    endtask

    task automatic expectGnt(input bit done);
        expRec_t e;
        e = '{gnt: 1'b1, beat: 1'b0, done: done, we: 1'b0, re: 1'b0, stall: 1'b0,
              chkAddr: 1'b0, addr: 32'd0, func3: 3'd0, chkRd: 1'b0, rdata: 32'd0};
        expQ.push_back(e);
    endtask

    task automatic expectBeat(input bit we, input logic [31:0] addr, input bit done,
                              input bit stall, input logic [31:0] rd);
        expRec_t e;
        e = '{gnt: 1'b0, beat: 1'b1, done: done, we: we, re: !we, stall: stall,
              chkAddr: 1'b1, addr: addr, func3: 3'b010, chkRd: !we, rdata: rd};
        expQ.push_back(e);
    endtask

    task automatic expectDirect(input string name, input logic [31:0] act, input logic [31:0] exp);
        direct_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        directQ.push_back(d);
    endtask

    task automatic cpuStore(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, data, 3'b010, 1'b0, 1'b0, 32'd0, 8'd0);
        expectCpu(1'b1, addr, 3'b010, 32'd0);
        tick();
    endtask

    task automatic cpuLoad(input logic [31:0] addr, input logic [31:0] rd);
        applyStimulus(1'b1, 1'b0, addr, 32'd0, 3'b100, 1'b0, 1'b0, 32'd0, 8'd0);
        expectCpu(1'b0, addr, 3'b100, rd);
        tick();
    endtask

    task automatic goIdle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 32'd0, 8'd0);
    endtask

    // Monitor: compares any cycle where the memory port or accelerator strobes are active.
    task automatic checkOutput();
        expRec_t e;
        logic [31:0] rd;
        bit ok;
        checks++;
        evNum++;
        rd = acc_beat ? acc_rdata : cpu_rdata;
        if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpectedEvent#%0d: got gnt=%0b beat=%0b done=%0b we=%0b re=%0b addr=%h, expected no event",
                     evNum, acc_gnt, acc_beat, acc_done, mem_we, mem_re, mem_addr);
        end else begin
            e  = expQ.pop_front();
            ok = (acc_gnt == e.gnt) && (acc_beat == e.beat) && (acc_done == e.done) &&
                 (mem_we == e.we) && (mem_re == e.re) && (cpu_stall == e.stall);
            if (e.chkAddr && ((mem_addr !== e.addr) || (mem_func3 !== e.func3))) ok = 1'b0;
            if (e.chkRd && (rd !== e.rdata)) ok = 1'b0;
            if (!ok) begin
                fails++;
                $display("[TB] FAIL event#%0d: got gnt=%0b beat=%0b done=%0b we=%0b re=%0b stall=%0b addr=%h f3=%0d rd=%h, expected gnt=%0b beat=%0b done=%0b we=%0b re=%0b stall=%0b addr=%h f3=%0d rd=%h",
                         evNum, acc_gnt, acc_beat, acc_done, mem_we, mem_re, cpu_stall, mem_addr, mem_func3, rd,
                         e.gnt, e.beat, e.done, e.we, e.re, e.stall, e.addr, e.func3, e.rdata);
            end
        end
    endtask

    always @(negedge clk) begin
        while (directQ.size() > 0) begin
            direct_t d;
            d = directQ.pop_front();
            checks++;
            if (d.act !== d.exp) begin
                fails++;
                $display("[TB] FAIL %s: got %h, expected %h", d.name, d.act, d.exp);
            end
        end
        if (acc_gnt || acc_beat || acc_done || mem_we || mem_re) checkOutput();
        if (testDone) begin
            checks++;
            if (expQ.size() != 0) begin
                fails++;
                $display("[TB] FAIL missingEvents: got %0d pending, expected 0", expQ.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
    end

    initial begin
        acc_wdata = 32'd0;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h1, 3'b010, 1'b1, 1'b0, 32'h200, 8'd4);
        @(negedge clk);
        expectDirect("resetStrobes", {27'd0, acc_gnt, acc_beat, acc_done, mem_we, mem_re}, 32'd0);
        tick();
        reset = 1'b0;
        goIdle();
        tick();

        // CPU store in IDLE, then preload data for the bursts
        cpuStore(32'h100, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) cpuStore(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        cpuStore(32'hFFFF_FFF8, 32'hC000_0000);
        cpuStore(32'hFFFF_FFFC, 32'hC000_0001);
        cpuStore(32'h0000_0000, 32'hC000_0002);
        goIdle();
        expectDirect("memHoldsStore", memArr[32'h100 >> 2], 32'hDEADBEEF);
        cpuLoad(32'h100, 32'hDEADBEEF);
        goIdle();
        tick();

        // Read burst len 4, CPU idle; IDLE again on cycle 5
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, 32'h200, 8'd4);
        expectGnt(1'b0);
        tick();
        goIdle();
        for (int i = 0; i < 4; i++) begin
            expectBeat(1'b0, 32'h200 + 32'(4 * i), i == 3, 1'b0, 32'hA000_0000 + 32'(i));
            tick();
        end
        cpuLoad(32'h100, 32'hDEADBEEF);
        goIdle();
        tick();

        // Simultaneous requests: CPU first, burst granted after cpu_req drops
        applyStimulus(1'b1, 1'b0, 32'h100, 32'd0, 3'b100, 1'b1, 1'b0, 32'h200, 8'd1);
        expectCpu(1'b0, 32'h100, 3'b100, 32'hDEADBEEF);
        tick();
        cpu_req = 1'b0;
        expectGnt(1'b0);
        tick();
        goIdle();
        expectBeat(1'b0, 32'h200, 1'b1, 1'b0, 32'hA000_0000);
        tick();
        tick();

        // Zero-length burst
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b1, 32'h400, 8'd0);
        expectGnt(1'b1);
        tick();
        goIdle();
        tick();

        // Write burst len 5 with window 2 and CPU requesting throughout
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b1, 32'h300, 8'd5);
        expectGnt(1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h100, 32'd0, 3'b100, 1'b0, 1'b0, 32'd0, 8'd0);
        begin
            string pattern;
            int beatNo;
            pattern = "BBCBBCBC";
            beatNo  = 0;
            for (int c = 0; c < 8; c++) begin
                if (pattern[c] == "B") begin
                    acc_wdata = 32'hB000_0000 + 32'(beatNo);
                    expectBeat(1'b1, 32'h300 + 32'(4 * beatNo), beatNo == 4, 1'b1, 32'd0);
                    beatNo++;
                end else begin
                    expectCpu(1'b0, 32'h100, 3'b100, 32'hDEADBEEF);
                end
                tick();
            end
        end
        goIdle();
        for (int i = 0; i < 5; i++)
            expectDirect($sformatf("writeBeat%0d", i), memArr[(32'h300 >> 2) + i], 32'hB000_0000 + 32'(i));
        tick();

        // Address wrap across 2^32
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFF8, 8'd3);
        expectGnt(1'b0);
        tick();
        goIdle();
        expectBeat(1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'hC000_0000);
        tick();
        expectBeat(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hC000_0001);
        tick();
        expectBeat(1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'hC000_0002);
        tick();
        tick();

        // Same burst, aborted by reset after beat 1
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFF8, 8'd3);
        expectGnt(1'b0);
        tick();
        goIdle();
        expectBeat(1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'hC000_0000);
        tick();
        expectBeat(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hC000_0001);
        tick();
        reset = 1'b1;
        @(negedge clk);
        expectDirect("abortStrobes", {27'd0, acc_gnt, acc_beat, acc_done, mem_we, mem_re}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        cpuLoad(32'h100, 32'hDEADBEEF);
        goIdle();
        tick();
        tick();
        testDone = 1'b1;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
